// File: rtl/present_decrypt_core_pkg.sv
// Shared constants, S-box tables and key-schedule helpers for PRESENT-80 decryption.
// Optional key cache is enabled with PRESENT_DEC_KEY_CACHE_EN.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int BLK_W  = 64;
    localparam int KEY_W  = 80;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEYX,
        S_DEC,
        S_DONE
    } state_t;

    // Nibble n of each table sits at bits [4n+3:4n]
    localparam logic [63:0] SBOX_TBL  = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SINV_TBL  = 64'hA970364BD21C8FE5;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sinv(input logic [3:0] x);
        return SINV_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLK_W-1:0] sinv16(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int n = 0; n < BLK_W / 4; n++) begin
            r[4*n +: 4] = sinv(d[4*n +: 4]);
        end
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] fwd(
        input logic [KEY_W-1:0] k,
        input logic [CNT_W-1:0] rc
    );
        logic [KEY_W-1:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    // Exact inverse of fwd: undo the counter xor, the S-box, then the rotation
    function automatic logic [KEY_W-1:0] inv(
        input logic [KEY_W-1:0] k,
        input logic [CNT_W-1:0] rc
    );
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = sinv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/present_decrypt_core_if.sv
// Stream handshake bundle for the PRESENT-80 decryption core.
// The slave side is the core; the master side is the upstream/downstream client.
interface present_decrypt_core_if;
    import present_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] idat;
    logic [KEY_W-1:0] key;
    logic             new_key;
    logic [BLK_W-1:0] odat;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_valid,
        input  idat,
        input  key,
        input  new_key,
        input  out_ready,
        output in_ready,
        output odat,
        output out_valid
    );

    modport master (
        output in_valid,
        output idat,
        output key,
        output new_key,
        output out_ready,
        input  in_ready,
        input  odat,
        input  out_valid
    );

endinterface

// File: rtl/present_decrypt_pbox.sv
// Combinational inverse PRESENT p-layer: o[i] = d[16*i mod 63], bit 63 fixed.
module present_decrypt_pbox
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] idat,
    output logic [BLK_W-1:0] odat
);

    for (genvar i = 0; i < BLK_W - 1; i++) begin : g_bit
        assign odat[i] = idat[(16 * i) % (BLK_W - 1)];
    end

    assign odat[BLK_W-1] = idat[BLK_W-1];

endmodule

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryptor, one round per clock, reverse key schedule.
// Define PRESENT_DEC_KEY_CACHE_EN to keep K32 and skip expansion on key reuse.
module present_decrypt_core
    import present_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    present_decrypt_core_if.slave io
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BLK_W-1:0]   r_st;
    logic [KEY_W-1:0]   r_wk;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_acc;
    logic               w_hit;
    logic [KEY_W-1:0]   w_fwd;
    logic [KEY_W-1:0]   w_nk;
    logic [BLK_W-1:0]   w_pb;
    logic [BLK_W-1:0]   w_rnd;

`ifdef PRESENT_DEC_KEY_CACHE_EN
    logic [KEY_W-1:0]   r_dk;
    logic               r_dk_vld;
`endif

    assign w_acc = io.in_valid & (r_state == S_IDLE);

`ifdef PRESENT_DEC_KEY_CACHE_EN
    assign w_hit = w_acc & ~io.new_key & r_dk_vld;
`else
    assign w_hit = 1'b0;
`endif

    assign w_fwd = fwd(r_wk, r_cnt);
    assign w_nk  = inv(r_wk, r_cnt);

    present_decrypt_pbox u_pbox (
        .idat (r_st),
        .odat (w_pb)
    );

    assign w_rnd = sinv16(w_pb) ^ w_nk[KEY_W-1:16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = w_hit ? S_DEC : S_KEYX;
                end
            end
            S_KEYX: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DEC;
                end
            end
            S_DEC: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (io.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The state word is whitened with K32 on the last expansion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st  <= '0;
            r_wk  <= '0;
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
`ifdef PRESENT_DEC_KEY_CACHE_EN
                        if (w_hit) begin
                            r_st  <= io.idat ^ r_dk[KEY_W-1:16];
                            r_wk  <= r_dk;
                            r_cnt <= CNT_LAST;
                        end else begin
                            r_st  <= io.idat;
                            r_wk  <= io.key;
                            r_cnt <= CNT_W'(1);
                        end
`else
                        r_st  <= io.idat;
                        r_wk  <= io.key;
                        r_cnt <= CNT_W'(1);
`endif
                    end
                end
                S_KEYX: begin
                    r_wk <= w_fwd;
                    if (r_cnt == CNT_LAST) begin
                        r_st <= r_st ^ w_fwd[KEY_W-1:16];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DEC: begin
                    r_st  <= w_rnd;
                    r_wk  <= w_nk;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PRESENT_DEC_KEY_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dk     <= '0;
            r_dk_vld <= 1'b0;
        end else if (r_state == S_KEYX && r_cnt == CNT_LAST) begin
            r_dk     <= w_fwd;
            r_dk_vld <= 1'b1;
        end
    end
`endif

    assign io.in_ready  = (r_state == S_IDLE);
    assign io.out_valid = (r_state == S_DONE);
    assign io.odat      = (r_state == S_DONE) ? r_st : '0;

endmodule
